antares_div_unit: RTL and testbench
===================================

ANTARES_DIV_UNIT -- requirements
Module: antares_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port op_divs  input  1  start signed division (one-cycle request).
REQ-005 The block SHALL have port op_divu  input  1  start unsigned division (one-cycle request).
REQ-006 The block SHALL have port dividend  input  WIDTH  numerator, driven by the upstream operand-forwarding mux.
REQ-007 The block SHALL have port divisor  input  WIDTH  denominator, driven by the upstream operand-forwarding mux.
REQ-008 The block SHALL have port flush  input  1  synchronous abort of an in-progress operation.
REQ-009 The block SHALL have port quotient  output  WIDTH  registered quotient result.
REQ-010 The block SHALL have port remainder  output  WIDTH  registered remainder result.
REQ-011 The block SHALL have port busy  output  1  operation in progress; pipeline stall source.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse marking new valid results.

Function
REQ-013 The block SHALL implement two states: IDLE and BUSY; all outputs SHALL be registered.
REQ-014 In IDLE, a rising edge with op_divs or op_divu high and flush low SHALL load operands, set busy=1, enter BUSY (start edge E0).
REQ-015 When op_divs and op_divu are both high, the request SHALL be treated as signed.
REQ-016 dividend/divisor SHALL be sampled only at E0; changes during BUSY SHALL have no effect.
REQ-017 For signed requests, operands SHALL be converted to magnitudes at E0 and their signs recorded; unsigned requests use operands unmodified.
REQ-018 The datapath SHALL be radix-2 restoring: one quotient bit per edge, WIDTH iterations at edges E1..E_WIDTH, tracked by a counter of ceil(log2(WIDTH))+1 bits.
REQ-019 At edge E_WIDTH the block SHALL write quotient/remainder, clear busy, set done=1, return to IDLE; latency start-to-done is WIDTH cycles.
REQ-020 done SHALL be high for exactly one cycle; quotient/remainder SHALL hold their values until the next completed operation.
REQ-021 Signed sign fix-up: quotient negated (two's complement) when operand signs differ; remainder takes the sign of the dividend.
REQ-022 Divisor zero (either mode): quotient SHALL be all ones, remainder SHALL equal the original dividend, with normal latency and no error flag.
REQ-023 Signed overflow (most-negative / -1): quotient SHALL be the most-negative value, remainder 0.
REQ-024 op_divs/op_divu asserted while BUSY SHALL be ignored (no queueing); a request at the same edge that done is asserted SHALL be accepted (back-to-back start from IDLE next cycle only).
REQ-025 flush high at any edge in BUSY SHALL return the block to IDLE at that edge, busy=0, done=0, quotient/remainder unchanged.
REQ-026 flush high in IDLE SHALL suppress any simultaneous start request.
REQ-027 The block SHALL not assert done for an aborted operation.

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, quotient=0, remainder=0, counter=0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no done pulse; release SHALL be synchronous to clk in effect (first start accepted at the first rising edge with rst_n high).

Verification
REQ-030 divu 100/7 -> busy high 32 cycles, done pulse at E32, quotient=14, remainder=2.
REQ-031 divs 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); divs 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-032 divu 5/0 and divs 0x80000000/0 -> quotient=0xFFFFFFFF, remainder=dividend; divs 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-033 divu 100/7 started, flush at E10 -> busy=0 next cycle, no done, outputs keep previous result; new divu 9/3 then completes with quotient=3, remainder=0.
REQ-034 rst_n pulsed low at E15 of an operation -> all outputs 0 immediately, no done; second op_divu during BUSY ignored and operand changes during BUSY do not alter result.

Source files
------------

// File: rtl/antares_div_unit.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned, one quotient bit per clock.
// Results are registered and held until the next completed operation; flush aborts silently.
module antares_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_divs,
    input  logic             op_divu,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;       // partial remainder
    logic [WIDTH-1:0] qsh;       // dividend shifts out as quotient bits shift in
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] orig_dvd;
    logic             neg_q, neg_r, dz;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] acc_nx, qsh_nx, q_fix, r_fix;
    logic             sgn, dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;

    always_comb begin
        // acc < dvs always holds, so bit WIDTH of the trial difference is the borrow
        trial = {acc, qsh[WIDTH-1]} - {1'b0, dvs};
        if (!trial[WIDTH]) begin
            acc_nx = trial[WIDTH-1:0];
            qsh_nx = {qsh[WIDTH-2:0], 1'b1};
        end else begin
            acc_nx = {acc[WIDTH-2:0], qsh[WIDTH-1]};
            qsh_nx = {qsh[WIDTH-2:0], 1'b0};
        end
        q_fix = neg_q ? (~qsh_nx + 1'b1) : qsh_nx;
        r_fix = neg_r ? (~acc_nx + 1'b1) : acc_nx;

        sgn     = op_divs;
        dvd_neg = sgn & dividend[WIDTH-1];
        dvs_neg = sgn & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            qsh       <= '0;
            dvs       <= '0;
            orig_dvd  <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if ((op_divs || op_divu) && !flush) begin
                        state    <= BUSY;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        acc      <= '0;
                        qsh      <= dvd_mag;
                        dvs      <= dvs_mag;
                        orig_dvd <= dividend;
                        neg_q    <= dvd_neg ^ dvs_neg;
                        neg_r    <= dvd_neg;
                        dz       <= (divisor == '0);
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        acc <= acc_nx;
                        qsh <= qsh_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cnt       <= '0;
                            quotient  <= dz ? '1 : q_fix;
                            remainder <= dz ? orig_dvd : r_fix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_antares_div_unit.sv
// Directed bench for antares_div_unit: latency, signed fix-up, divide-by-zero,
// overflow, flush and asynchronous reset behaviour.
module tb_antares_div_unit;

    logic        clk, rst_n, op_divs, op_divu, flush;
    logic [31:0] dividend, divisor, quotient, remainder;
    logic        busy, done;
    int          tests = 0, failed = 0;

    antares_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .op_divs(op_divs), .op_divu(op_divu),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge; the following posedge is E0.
    task automatic start(input logic s, input logic u, input logic [31:0] a, input logic [31:0] b);
        op_divs = s; op_divu = u; dividend = a; divisor = b;
        @(negedge clk);
        op_divs = 1'b0; op_divu = 1'b0;
    endtask

    // Returns k where done is first seen after edge E_k; -1 if never.
    task automatic wait_done(input int from, output int lat);
        lat = -1;
        for (int i = from; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
    endtask

    task automatic run(input string tag, input logic s, input logic u,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er);
        int lat;
        start(s, u, a, b);
        wait_done(1, lat);
        chk({tag, "_lat"}, lat, 32);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
    endtask

    initial begin
        int lat, ndone;
        rst_n = 1'b0; op_divs = 1'b0; op_divu = 1'b0; flush = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 100/7 with an ignored second request and operand changes while busy
        start(1'b0, 1'b1, 32'd100, 32'd7);
        chk("u100_busy", {31'b0, busy}, 1);
        op_divu = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        op_divu = 1'b0; dividend = 32'd55;
        wait_done(2, lat);
        chk("u100_lat", lat, 32);
        chk("u100_q", quotient, 14);
        chk("u100_r", remainder, 2);
        chk("u100_busy_end", {31'b0, busy}, 0);
        @(negedge clk);
        chk("u100_done_pulse", {31'b0, done}, 0);
        chk("u100_hold_q", quotient, 14);
        chk("u100_busy_idle", {31'b0, busy}, 0);

        run("s_m7_2", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run("s_7_m2", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
        run("u_5_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
        run("s_min_0", 1'b1, 1'b0, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'h80000000);
        run("s_ovf", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        run("both_hi", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run("u_big_2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1);

        // back-to-back: request presented while done is high
        chk("b2b_done", {31'b0, done}, 1);
        start(1'b0, 1'b1, 32'd20, 32'd6);
        chk("b2b_busy", {31'b0, busy}, 1);
        wait_done(1, lat);
        chk("b2b_lat", lat, 32);
        chk("b2b_q", quotient, 3);
        chk("b2b_r", remainder, 2);
        @(negedge clk);

        // flush at E10
        start(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 0);
        chk("flush_done", {31'b0, done}, 0);
        chk("flush_q", quotient, 3);
        chk("flush_r", remainder, 2);
        ndone = 0;
        repeat (40) begin @(negedge clk); if (done) ndone++; end
        chk("flush_no_done", ndone, 0);
        run("after_flush", 1'b0, 1'b1, 32'd9, 32'd3, 32'd3, 32'd0);
        @(negedge clk);

        // flush in IDLE suppresses a start
        op_divu = 1'b1; flush = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        op_divu = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", {31'b0, busy}, 0);

        // asynchronous reset at E15
        start(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_done", {31'b0, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin @(negedge clk); if (done) ndone++; end
        chk("arst_no_done", ndone, 0);
        run("after_rst", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
